// File: rtl/trigger_match_ctrl_pkg.sv
// rtl/trigger_match_ctrl_pkg.sv - shared mcontrol field positions, trigger type and FSM encodings
// Purpose: common definitions for trigger_match_ctrl and trig_match_unit.
// Ports: none (package).
package trigger_match_ctrl_pkg;

  // mcontrol field positions
  localparam int MCTRL_TYPE_MSB   = 31;
  localparam int MCTRL_TYPE_LSB   = 28;
  localparam int MCTRL_HIT_BIT    = 20;
  localparam int MCTRL_ACTION_MSB = 15;
  localparam int MCTRL_ACTION_LSB = 12;
  localparam int MCTRL_M_BIT      = 6;
  localparam int MCTRL_U_BIT      = 3;
  localparam int MCTRL_EXEC_BIT   = 2;
  localparam int MCTRL_STORE_BIT  = 1;
  localparam int MCTRL_LOAD_BIT   = 0;

  localparam logic [3:0] MCTRL_TYPE = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_DBG_WAIT = 2'd2,
    ST_DBG_ACT  = 2'd3
  } trig_state_e;

  // Only action 0 (breakpoint) and 1 (debug entry) are supported; anything
  // else, or a non-mcontrol type, leaves the trigger inert.
  function automatic logic mctrl_enabled(input logic [31:0] mctrl);
    return (mctrl[MCTRL_TYPE_MSB:MCTRL_TYPE_LSB] == MCTRL_TYPE) &&
           (mctrl[MCTRL_ACTION_MSB:MCTRL_ACTION_LSB+1] == 3'd0);
  endfunction

endpackage

// File: rtl/trigger_match_ctrl_trig_match_unit.sv
// rtl/trigger_match_ctrl_trig_match_unit.sv - one trigger's qualify/compare logic
// Purpose: combinational match bit for a single mcontrol trigger.
// Ports: mctrl/tdata2 trigger config; pc_valid/pc execute stream;
//        mem_valid/mem_wr/mem_addr load-store stream; priv_m privilege;
//        match qualified hit; action captured action bit (0 brk, 1 debug).
import trigger_match_ctrl_pkg::*;

module trig_match_unit (
  input  logic [31:0] mctrl,
  input  logic [31:0] tdata2,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  input  logic        mem_valid,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic        priv_m,
  output logic        match,
  output logic        action
);

  logic enabled;
  logic priv_ok;
  logic exec_hit;
  logic load_hit;
  logic store_hit;
  logic unused_bits;

  assign enabled   = mctrl_enabled(mctrl);
  assign priv_ok   = (mctrl[MCTRL_M_BIT] & priv_m) | (mctrl[MCTRL_U_BIT] & ~priv_m);
  assign exec_hit  = mctrl[MCTRL_EXEC_BIT] & pc_valid & (pc == tdata2);
  assign load_hit  = mctrl[MCTRL_LOAD_BIT] & mem_valid & ~mem_wr & (mem_addr == tdata2);
  assign store_hit = mctrl[MCTRL_STORE_BIT] & mem_valid & mem_wr & (mem_addr == tdata2);

  assign match  = enabled & priv_ok & (exec_hit | load_hit | store_hit);
  assign action = mctrl[MCTRL_ACTION_LSB];

  // Fields that do not take part in matching (hit bit is set elsewhere).
  assign unused_bits = ^{mctrl[MCTRL_TYPE_LSB-1:MCTRL_HIT_BIT+1], mctrl[MCTRL_HIT_BIT],
                         mctrl[MCTRL_HIT_BIT-1:MCTRL_ACTION_MSB+1],
                         mctrl[MCTRL_ACTION_LSB-1:MCTRL_M_BIT+1],
                         mctrl[MCTRL_M_BIT-1:MCTRL_U_BIT+1]};

endmodule

// File: rtl/trigger_match_ctrl.sv
// rtl/trigger_match_ctrl.sv - two-trigger match controller with request/ack handshake
// Purpose: evaluates two mcontrol triggers, reports the winning hit through a
//          trig_req/trig_ack handshake and tracks debug-mode entry/exit.
// Optional: KRV_TRIG_HITCNT_EN adds saturating per-trigger hit counters.
// Ports: cpu_clk/cpu_rstn clock and async active-low reset;
//        mctrl_t0/t1, tdata2_t0/t1 trigger configuration;
//        pc_valid/pc, mem_valid/mem_wr/mem_addr match sources;
//        priv_m, dbg_mode core state;
//        trig_req/trig_ack/trig_action/trig_id request handshake;
//        hit_set one-cycle pulse to set mcontrol hit bit;
//        hit_cnt_clr/hit_cnt_t0/hit_cnt_t1 counters (KRV_TRIG_HITCNT_EN only).
import trigger_match_ctrl_pkg::*;

module trigger_match_ctrl (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic [31:0] mctrl_t0,
  input  logic [31:0] mctrl_t1,
  input  logic [31:0] tdata2_t0,
  input  logic [31:0] tdata2_t1,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  input  logic        mem_valid,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic        priv_m,
  input  logic        dbg_mode,
  output logic        trig_req,
  input  logic        trig_ack,
  output logic        trig_action,
  output logic        trig_id,
  output logic [1:0]  hit_set
`ifdef KRV_TRIG_HITCNT_EN
  ,
  input  logic        hit_cnt_clr,
  output logic [15:0] hit_cnt_t0,
  output logic [15:0] hit_cnt_t1
`endif
);

  trig_state_e state_q;
  trig_state_e state_d;
  logic        capture;
  logic        match0;
  logic        match1;
  logic        action0;
  logic        action1;

  trig_match_unit u_match_t0 (
    .mctrl     (mctrl_t0),
    .tdata2    (tdata2_t0),
    .pc_valid  (pc_valid),
    .pc        (pc),
    .mem_valid (mem_valid),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .priv_m    (priv_m),
    .match     (match0),
    .action    (action0)
  );

  trig_match_unit u_match_t1 (
    .mctrl     (mctrl_t1),
    .tdata2    (tdata2_t1),
    .pc_valid  (pc_valid),
    .pc        (pc),
    .mem_valid (mem_valid),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .priv_m    (priv_m),
    .match     (match1),
    .action    (action1)
  );

  // Matches are only acted on from IDLE outside debug mode; in every other
  // state they are simply not looked at, which drops them.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!dbg_mode && (match0 || match1)) begin
          state_d = ST_REQ;
          capture = 1'b1;
        end
      end
      ST_REQ: begin
        if (trig_ack) begin
          state_d = trig_action ? ST_DBG_WAIT : ST_IDLE;
        end
      end
      ST_DBG_WAIT: begin
        if (dbg_mode) begin
          state_d = ST_DBG_ACT;
        end
      end
      ST_DBG_ACT: begin
        if (!dbg_mode) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // id/action are only loaded on capture so later mctrl/tdata2 edits cannot
  // disturb an outstanding request; trigger 0 wins a simultaneous match.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q     <= ST_IDLE;
      trig_id     <= 1'b0;
      trig_action <= 1'b0;
      hit_set     <= 2'b00;
    end else begin
      state_q <= state_d;
      hit_set <= 2'b00;
      if (capture) begin
        trig_id     <= ~match0;
        trig_action <= match0 ? action0 : action1;
        hit_set     <= match0 ? 2'b01 : 2'b10;
      end
    end
  end

  assign trig_req = (state_q == ST_REQ);

`ifdef KRV_TRIG_HITCNT_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  // Counters follow the hit_set pulse; clear wins over a same-cycle pulse.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else if (hit_cnt_clr) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      if (hit_set[0] && (cnt0_q != 16'hFFFF)) begin
        cnt0_q <= cnt0_q + 16'd1;
      end
      if (hit_set[1] && (cnt1_q != 16'hFFFF)) begin
        cnt1_q <= cnt1_q + 16'd1;
      end
    end
  end

  assign hit_cnt_t0 = cnt0_q;
  assign hit_cnt_t1 = cnt1_q;
`endif

endmodule

// File: tb/tb_trigger_match_ctrl.sv
// tb/tb_trigger_match_ctrl.sv - self-checking bench for trigger_match_ctrl
module tb_trigger_match_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic [31:0] mctrl_t0 = '0;
  logic [31:0] mctrl_t1 = '0;
  logic [31:0] tdata2_t0 = '0;
  logic [31:0] tdata2_t1 = '0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        mem_valid = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        priv_m = 1'b1;
  logic        dbg_mode = 1'b0;
  logic        trig_req;
  logic        trig_ack = 1'b0;
  logic        trig_action;
  logic        trig_id;
  logic [1:0]  hit_set;
`ifdef KRV_TRIG_HITCNT_EN
  logic        hit_cnt_clr = 1'b0;
  logic [15:0] hit_cnt_t0;
  logic [15:0] hit_cnt_t1;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 0;

  trigger_match_ctrl dut (
    .cpu_clk     (cpu_clk),
    .cpu_rstn    (cpu_rstn),
    .mctrl_t0    (mctrl_t0),
    .mctrl_t1    (mctrl_t1),
    .tdata2_t0   (tdata2_t0),
    .tdata2_t1   (tdata2_t1),
    .pc_valid    (pc_valid),
    .pc          (pc),
    .mem_valid   (mem_valid),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .priv_m      (priv_m),
    .dbg_mode    (dbg_mode),
    .trig_req    (trig_req),
    .trig_ack    (trig_ack),
    .trig_action (trig_action),
    .trig_id     (trig_id),
    .hit_set     (hit_set)
`ifdef KRV_TRIG_HITCNT_EN
    ,
    .hit_cnt_clr (hit_cnt_clr),
    .hit_cnt_t0  (hit_cnt_t0),
    .hit_cnt_t1  (hit_cnt_t1)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  // Model: an outstanding request, a pending debug entry, and being in debug.
  bit          m_req = 0;
  bit          m_wait_dbg = 0;
  bit          m_in_dbg = 0;
  bit          m_id = 0;
  bit          m_act = 0;
  bit [1:0]    m_hit = 0;
  bit [15:0]   m_cnt0 = 0;
  bit [15:0]   m_cnt1 = 0;

  function automatic bit trig_hits(input logic [31:0] mc, input logic [31:0] td);
    bit en, priv_ok, ex, ld, st;
    en = (mc[31:28] == 4'd2) && ((mc[15:12] == 4'd0) || (mc[15:12] == 4'd1));
    priv_ok = priv_m ? mc[6] : mc[3];
    ex = mc[2] && pc_valid && (pc == td);
    ld = mc[0] && mem_valid && !mem_wr && (mem_addr == td);
    st = mc[1] && mem_valid && mem_wr && (mem_addr == td);
    return en && priv_ok && (ex || ld || st);
  endfunction

  always @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      m_req = 0; m_wait_dbg = 0; m_in_dbg = 0;
      m_id = 0; m_act = 0; m_hit = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      bit h0, h1;
`ifdef KRV_TRIG_HITCNT_EN
      if (hit_cnt_clr) begin
        m_cnt0 = 0; m_cnt1 = 0;
      end else begin
        if (m_hit[0] && m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 1;
        if (m_hit[1] && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 1;
      end
`endif
      m_hit = 0;
      h0 = trig_hits(mctrl_t0, tdata2_t0);
      h1 = trig_hits(mctrl_t1, tdata2_t1);
      if (m_req) begin
        if (trig_ack) begin
          m_req = 0;
          m_wait_dbg = m_act;
        end
      end else if (m_wait_dbg) begin
        if (dbg_mode) begin m_wait_dbg = 0; m_in_dbg = 1; end
      end else if (m_in_dbg) begin
        if (!dbg_mode) m_in_dbg = 0;
      end else if (!dbg_mode && (h0 || h1)) begin
        m_req = 1;
        m_id  = !h0;
        m_act = h0 ? mctrl_t0[12] : mctrl_t1[12];
        m_hit = h0 ? 2'b01 : 2'b10;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge cpu_clk) begin
    if (started) begin
      chk("m_req", {31'd0, trig_req}, {31'd0, m_req});
      chk("m_id", {31'd0, trig_id}, {31'd0, m_id});
      chk("m_act", {31'd0, trig_action}, {31'd0, m_act});
      chk("m_hit", {30'd0, hit_set}, {30'd0, m_hit});
`ifdef KRV_TRIG_HITCNT_EN
      chk("m_cnt0", {16'd0, hit_cnt_t0}, {16'd0, m_cnt0});
      chk("m_cnt1", {16'd0, hit_cnt_t1}, {16'd0, m_cnt1});
`endif
    end
  end

  task automatic cyc();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic dbg_roundtrip();
    dbg_mode = 1'b1; cyc();
    chk("dbg_act_noreq", {31'd0, trig_req}, 32'd0);
    dbg_mode = 1'b0; cyc();
  endtask

  initial begin
    cyc(); cyc();
    cpu_rstn = 1'b1;
    started = 1;
    chk("rst_req", {31'd0, trig_req}, 32'd0);
    chk("rst_hit", {30'd0, hit_set}, 32'd0);
    chk("rst_id", {31'd0, trig_id}, 32'd0);
    chk("rst_act", {31'd0, trig_action}, 32'd0);

    // ack outside REQ is ignored
    trig_ack = 1'b1; cyc(); trig_ack = 1'b0;
    chk("stray_ack", {31'd0, trig_req}, 32'd0);

    // execute trigger, debug-entry action
    mctrl_t0 = 32'h2000_1044; tdata2_t0 = 32'h100; priv_m = 1'b1;
    pc = 32'h100; pc_valid = 1'b1;
    cyc();
    chk("t1_hit", {30'd0, hit_set}, 32'd1);
    chk("t1_req", {31'd0, trig_req}, 32'd1);
    chk("t1_id", {31'd0, trig_id}, 32'd0);
    chk("t1_act", {31'd0, trig_action}, 32'd1);
    pc_valid = 1'b0; cyc();
    chk("t1_hit_pulse", {30'd0, hit_set}, 32'd0);
    chk("t1_req_hold", {31'd0, trig_req}, 32'd1);
    trig_ack = 1'b1; cyc(); trig_ack = 1'b0;
    chk("t1_wait", {31'd0, trig_req}, 32'd0);
    pc_valid = 1'b1; cyc(); pc_valid = 1'b0;
    chk("t1_wait_drop", {31'd0, trig_req}, 32'd0);
    dbg_roundtrip();

    // both triggers match; trigger 0 wins
    mctrl_t1 = 32'h2000_0044; tdata2_t0 = 32'h200; tdata2_t1 = 32'h200;
    pc = 32'h200; pc_valid = 1'b1;
    cyc();
    chk("t2_hit", {30'd0, hit_set}, 32'd1);
    chk("t2_id", {31'd0, trig_id}, 32'd0);
    pc_valid = 1'b0; trig_ack = 1'b1; cyc(); trig_ack = 1'b0;
    dbg_roundtrip();

    // store trigger on t1, breakpoint action
    mctrl_t0 = 32'h0; mctrl_t1 = 32'h2000_0042; tdata2_t1 = 32'h8000;
    mem_addr = 32'h8000; mem_wr = 1'b1; mem_valid = 1'b1;
    cyc();
    chk("t3_hit", {30'd0, hit_set}, 32'd2);
    chk("t3_id", {31'd0, trig_id}, 32'd1);
    chk("t3_act", {31'd0, trig_action}, 32'd0);
    mem_valid = 1'b0; trig_ack = 1'b1; cyc(); trig_ack = 1'b0;
    chk("t3_idle", {31'd0, trig_req}, 32'd0);
    mem_wr = 1'b0; mem_valid = 1'b1; cyc();
    chk("t3_load_nomatch", {31'd0, trig_req}, 32'd0);
    mem_wr = 1'b1; priv_m = 1'b0; cyc();
    chk("t3_priv_nomatch", {31'd0, trig_req}, 32'd0);
    priv_m = 1'b1; mem_valid = 1'b0; cyc();

    // ack held low while new matches arrive and config changes
    mem_valid = 1'b1; cyc();
    chk("t4_req", {31'd0, trig_req}, 32'd1);
    mctrl_t1 = 32'h2000_1042; mctrl_t0 = 32'h2000_1044; tdata2_t0 = 32'h100;
    pc = 32'h100; pc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_req_hold", {31'd0, trig_req}, 32'd1);
      chk("t4_id_hold", {31'd0, trig_id}, 32'd1);
      chk("t4_act_hold", {31'd0, trig_action}, 32'd0);
      chk("t4_no_hit", {30'd0, hit_set}, 32'd0);
    end
    pc_valid = 1'b0; mem_valid = 1'b0; trig_ack = 1'b1; cyc(); trig_ack = 1'b0;
    chk("t4_idle", {31'd0, trig_req}, 32'd0);
    cyc();

    // reset mid-handshake
    pc_valid = 1'b1; cyc();
    chk("t5_req", {31'd0, trig_req}, 32'd1);
    #2 cpu_rstn = 1'b0;
    #1;
    chk("t5_rst_req", {31'd0, trig_req}, 32'd0);
    chk("t5_rst_id", {31'd0, trig_id}, 32'd0);
    chk("t5_rst_act", {31'd0, trig_action}, 32'd0);
    cyc();
    cpu_rstn = 1'b1;
    cyc();
    chk("t5_after_req", {31'd0, trig_req}, 32'd1);
    chk("t5_after_hit", {30'd0, hit_set}, 32'd1);
    pc_valid = 1'b0; trig_ack = 1'b1; cyc(); trig_ack = 1'b0;
    dbg_roundtrip();

`ifdef KRV_TRIG_HITCNT_EN
    hit_cnt_clr = 1'b1; cyc(); hit_cnt_clr = 1'b0;
    mctrl_t0 = 32'h2000_0044;
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; cyc();
      pc_valid = 1'b0; trig_ack = 1'b1; cyc(); trig_ack = 1'b0;
    end
    cyc();
    chk("cnt_three", {16'd0, hit_cnt_t0}, 32'd3);
    force dut.cnt0_q = 16'hFFFF;
    m_cnt0 = 16'hFFFF;
    cyc();
    release dut.cnt0_q;
    pc_valid = 1'b1; cyc();
    pc_valid = 1'b0; trig_ack = 1'b1; cyc(); trig_ack = 1'b0;
    cyc();
    chk("cnt_sat", {16'd0, hit_cnt_t0}, 32'h0000_FFFF);
    pc_valid = 1'b1; cyc();
    pc_valid = 1'b0; trig_ack = 1'b1; hit_cnt_clr = 1'b1; cyc();
    trig_ack = 1'b0; hit_cnt_clr = 1'b0;
    chk("cnt_clr_prio", {16'd0, hit_cnt_t0}, 32'd0);
    cyc();
`endif

    started = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_match_ctrl.md
TRIGGER_MATCH_CTRL -- requirements
Module: trigger_match_ctrl

Interface
REQ-001 SHALL have ports `cpu_clk` in 1 (clock), then `cpu_rstn` in 1 (reset); one clock; reset asynchronous, active-low.
REQ-002 SHALL have ports `mctrl_t0`, `mctrl_t1` in 32: mcontrol word of triggers 0 and 1.
REQ-003 SHALL have ports `tdata2_t0`, `tdata2_t1` in 32: compare values of triggers 0 and 1.
REQ-004 SHALL have ports `pc_valid` in 1 and `pc` in 32: executing instruction address.
REQ-005 SHALL have ports `mem_valid` in 1, `mem_wr` in 1 (1=store), `mem_addr` in 32: load/store address.
REQ-006 SHALL have ports `priv_m` in 1 (1=M-mode, 0=U-mode) and `dbg_mode` in 1.
REQ-007 SHALL have ports `trig_req` out 1, `trig_ack` in 1, `trig_action` out 1 (0=breakpoint exception, 1=debug entry), `trig_id` out 1.
REQ-008 SHALL have port `hit_set` out 2: one-cycle pulse that sets hit bit (mcontrol[20]) of trigger n.

Function
REQ-009 A trigger SHALL be enabled only when mcontrol[31:28]==2 and action field [15:12] is 0 or 1; all other encodings mean disabled.
REQ-010 Privilege qualification SHALL pass when (mcontrol[6] & priv_m) | (mcontrol[3] & !priv_m).
REQ-011 An execute match SHALL be mcontrol[2] & pc_valid & pc==tdata2, compared as full 32-bit equality.
REQ-012 A load match SHALL be mcontrol[0] & mem_valid & !mem_wr & mem_addr==tdata2, compared as full 32-bit equality.
REQ-013 A store match SHALL be mcontrol[1] & mem_valid & mem_wr & mem_addr==tdata2, compared as full 32-bit equality.
REQ-014 Matches SHALL be evaluated combinationally each cycle but acted on only in state IDLE with dbg_mode==0; matches in any other state SHALL be dropped.
REQ-015 FSM states SHALL be IDLE, REQ, DBG_WAIT, DBG_ACT.
REQ-016 IDLE->REQ SHALL occur on a qualified match; on that edge, trig_id, trig_action and the selected hit_set bit SHALL be captured, with hit_set pulsed for exactly one cycle.
REQ-017 When both triggers match in the same cycle, trigger 0 SHALL win, and only hit_set[0] SHALL pulse.
REQ-018 trig_req SHALL be 1 exactly in REQ and SHALL stay high until sampled with trig_ack==1; trig_id and trig_action SHALL stay stable while trig_req is high.
REQ-019 REQ with ack: action 0 SHALL go to IDLE; action 1 SHALL go to DBG_WAIT.
REQ-020 DBG_WAIT->DBG_ACT SHALL occur when dbg_mode==1, and DBG_ACT->IDLE SHALL occur when dbg_mode==0.
REQ-021 Changes to mctrl/tdata2 while in REQ SHALL NOT alter the captured id/action.
REQ-022 trig_ack received outside REQ SHALL be ignored.

Reset
REQ-023 On cpu_rstn low, the FSM SHALL go to IDLE and trig_req, trig_action, trig_id, hit_set and counters SHALL be 0, asynchronously, including mid-handshake; the first match after release SHALL be handled normally.

Configuration
REQ-024 With macro `KRV_TRIG_HITCNT_EN` defined, the block SHALL add ports `hit_cnt_clr` in 1, `hit_cnt_t0` out 16 and `hit_cnt_t1` out 16.
REQ-025 With `KRV_TRIG_HITCNT_EN` defined, each counter SHALL increment by one on its hit_set pulse.
REQ-026 With `KRV_TRIG_HITCNT_EN` defined, counters SHALL saturate at 16'hFFFF.
REQ-027 With `KRV_TRIG_HITCNT_EN` defined, hit_cnt_clr SHALL zero both counters and take priority over a simultaneous increment.
REQ-028 Without `KRV_TRIG_HITCNT_EN`, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 The shared defines header SHALL hold mcontrol field positions (type, action, m, u, execute, store, load, hit), MCTRL_TYPE=2, and the FSM state encodings.
REQ-030 One sub-module, `trig_match_unit` (one trigger's qualify/compare logic producing a match bit), SHALL be instantiated twice.

Verification
REQ-031 Bench SHALL cover: t0 mctrl=0x2000_1044 (type2, action1, M, execute), tdata2_t0=0x100, priv_m=1, pc_valid at pc=0x100 -> hit_set=01 for one cycle; next cycle trig_req=1, id=0, action=1; ack -> DBG_WAIT; dbg_mode 1 then 0 -> IDLE.
REQ-032 Bench SHALL cover: both triggers execute-match pc=0x200 -> only trigger 0 is reported and only hit_set[0] pulses.
REQ-033 Bench SHALL cover: t1 store trigger, action 0, mem_addr=0x8000, mem_wr=1 -> req with id=1, action=0; ack -> IDLE; the identical access with mem_wr=0 produces no match.
REQ-034 Bench SHALL cover: ack held 0 for 5 cycles while a new match occurs -> trig_req stays high, id/action stay unchanged, and the second match is dropped.
REQ-035 Bench SHALL cover: cpu_rstn asserted while in REQ -> trig_req=0 and FSM in IDLE immediately; a match after release is handled.
REQ-036 Bench SHALL cover, with `KRV_TRIG_HITCNT_EN` defined: 3 t0 hits -> hit_cnt_t0=3; counter preset to 0xFFFF plus a hit -> stays 0xFFFF; hit_cnt_clr coinciding with a hit -> 0.
